// File: rtl/stream_requantize_if.sv
// Valid/ready beat channel used on both sides of stream_requantize.
// The master drives valid/data, the slave drives ready; a beat moves when valid & ready.
interface stream_requantize_if #(
   parameter int unsigned Width = 8
);
   logic             valid;
   logic             ready;
   logic [Width-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_requantize.sv
// Per-channel bias, round, arithmetic shift, optional ReLU and saturation behind a valid/ready pipeline.
// Define STREAM_REQUANTIZE_STATS_EN to enable the saturation event counter on sat_count_o.
module stream_requantize #(
   parameter int unsigned Channels        = 8,
   parameter int unsigned SumWidth        = 37,
   parameter int unsigned ActivationWidth = 10,
   parameter int unsigned ShiftWidth      = 6,
   parameter int unsigned DefaultShift    = 8,
   parameter bit          DefaultReLU     = 1'b1,
   parameter int unsigned Stages          = 2,
   parameter logic signed [Channels-1:0][SumWidth-1:0] Bias = '0
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   stream_requantize_if.slave    slave,
   stream_requantize_if.master   master,
   input  logic                  cfg_write_i,
   input  logic [ShiftWidth-1:0] cfg_shift_i,
   input  logic                  cfg_relu_i,
   output logic                  cfg_busy_o,
   output logic [31:0]           sat_count_o
);
   // Two bits of headroom keep sum + bias + rounding term free of overflow.
   localparam int unsigned TW       = SumWidth + 2;
   localparam int unsigned AW       = ActivationWidth;
   localparam int unsigned ChainLen = Stages - 1;

   localparam logic signed [TW-1:0] ReluMax = {{(TW-AW){1'b0}}, {AW{1'b1}}};
   localparam logic signed [TW-1:0] SignMax = {{(TW-AW+1){1'b0}}, {(AW-1){1'b1}}};
   localparam logic signed [TW-1:0] SignMin = {{(TW-AW+1){1'b1}}, {(AW-1){1'b0}}};

   typedef logic [Channels*AW-1:0] act_t;

   if (Stages < 2 || Stages > 4) begin : g_bad_stages
      $error("stream_requantize: Stages must be in 2..4");
   end

   logic [ShiftWidth-1:0] shift_r;
   logic                  relu_r;
   logic [Stages-1:0]     valid, load, valid_in;
   logic                  accept;

   logic signed [TW-1:0]  t_d [Channels];
   logic signed [TW-1:0]  t_q [Channels];
   logic [ShiftWidth-1:0] shift_q;
   logic                  relu_q;

   act_t                  act_d;
   logic                  sat_d;
   act_t                  chain_q  [ChainLen];
   act_t                  chain_in [ChainLen];
   logic [ChainLen-1:0]   sat_q, sat_in;

   // Ready ripples back from the output: a stage may load if empty or if it empties this cycle.
   always_comb begin
      logic nxt;
      nxt  = master.ready;
      load = '0;
      for (int unsigned i = 0; i < Stages; i++) begin
         load[Stages-1-i] = !valid[Stages-1-i] || nxt;
         nxt              = load[Stages-1-i];
      end
   end

   assign slave.ready  = load[0];
   assign accept       = slave.valid && load[0];
   assign cfg_busy_o   = |valid;
   assign valid_in     = {valid[Stages-2:0], slave.valid};
   assign master.valid = valid[Stages-1];
   assign master.data  = chain_q[ChainLen-1];

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         shift_r <= ShiftWidth'(DefaultShift);
         relu_r  <= DefaultReLU;
      end else if (cfg_write_i && !cfg_busy_o && !accept) begin
         shift_r <= cfg_shift_i;
         relu_r  <= cfg_relu_i;
      end
   end

   // Rounding is skipped once the shift clears every bit; the shift then yields pure sign fill.
   always_comb begin
      logic signed [TW-1:0] rnd;
      rnd = '0;
      if (shift_r != '0 && 32'(shift_r) <= SumWidth)
         rnd = TW'(1) << (shift_r - ShiftWidth'(1));
      for (int unsigned c = 0; c < Channels; c++)
         t_d[c] = TW'(signed'(slave.data[c*SumWidth +: SumWidth]))
                + TW'($signed(Bias[c])) + rnd;
   end

   always_comb begin
      logic signed [TW-1:0] u;
      act_d = '0;
      sat_d = 1'b0;
      for (int unsigned c = 0; c < Channels; c++) begin
         u = t_q[c] >>> shift_q;
         if (relu_q) begin
            if (u[TW-1]) begin
               act_d[c*AW +: AW] = '0;
               sat_d             = 1'b1;
            end else if (u > ReluMax) begin
               act_d[c*AW +: AW] = '1;
               sat_d             = 1'b1;
            end else begin
               act_d[c*AW +: AW] = u[AW-1:0];
            end
         end else begin
            if (u > SignMax) begin
               act_d[c*AW +: AW] = SignMax[AW-1:0];
               sat_d             = 1'b1;
            end else if (u < SignMin) begin
               act_d[c*AW +: AW] = SignMin[AW-1:0];
               sat_d             = 1'b1;
            end else begin
               act_d[c*AW +: AW] = u[AW-1:0];
            end
         end
      end
   end

   always_comb begin
      chain_in[0] = act_d;
      sat_in[0]   = sat_d;
      for (int unsigned j = 1; j < ChainLen; j++) begin
         chain_in[j] = chain_q[j-1];
         sat_in[j]   = sat_q[j-1];
      end
   end

   // Stage 0 also latches the config so each beat keeps the settings present at acceptance.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         valid   <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
         sat_q   <= '0;
         for (int unsigned c = 0; c < Channels; c++) t_q[c] <= '0;
         for (int unsigned j = 0; j < ChainLen; j++) chain_q[j] <= '0;
      end else begin
         for (int unsigned k = 0; k < Stages; k++)
            if (load[k]) valid[k] <= valid_in[k];
         if (accept) begin
            t_q     <= t_d;
            shift_q <= shift_r;
            relu_q  <= relu_r;
         end
         for (int unsigned j = 0; j < ChainLen; j++) begin
            if (load[j+1] && valid_in[j+1]) begin
               chain_q[j] <= chain_in[j];
               sat_q[j]   <= sat_in[j];
            end
         end
      end
   end

`ifdef STREAM_REQUANTIZE_STATS_EN
   logic [31:0] sat_count;
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i)
         sat_count <= '0;
      else if (master.valid && master.ready && sat_q[ChainLen-1] && sat_count != '1)
         sat_count <= sat_count + 32'd1;
   end
   assign sat_count_o = sat_count;
`else
   logic unused_sat;
   assign unused_sat  = sat_q[ChainLen-1];
   assign sat_count_o = '0;
`endif

endmodule

// File: tb/tb_stream_requantize.sv
// Directed bench for stream_requantize: defaults, clamping, config gating, stalled streaming, mid-stream reset.
// Saturation counter expectations follow STREAM_REQUANTIZE_STATS_EN.
module tb_stream_requantize;
   localparam int unsigned CH = 8;
   localparam int unsigned SW = 37;
   localparam int unsigned AW = 10;
   localparam int unsigned ST = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_write;
   logic [5:0]  cfg_shift;
   logic        cfg_relu;
   logic        busy;
   logic [31:0] sat_count;

   stream_requantize_if #(.Width(CH*SW)) s_if ();
   stream_requantize_if #(.Width(CH*AW)) m_if ();

   stream_requantize #(
      .Channels(CH), .SumWidth(SW), .ActivationWidth(AW), .ShiftWidth(6),
      .DefaultShift(8), .DefaultReLU(1'b1), .Stages(ST)
   ) dut (
      .clock_i(clk), .reset_i(rst_n), .slave(s_if), .master(m_if),
      .cfg_write_i(cfg_write), .cfg_shift_i(cfg_shift), .cfg_relu_i(cfg_relu),
      .cfg_busy_o(busy), .sat_count_o(sat_count)
   );

   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned fails   = 0;
   int          sv [CH];
   int          av [CH];

   function automatic logic [CH*SW-1:0] pack_sums(input int v [CH]);
      logic [CH*SW-1:0] r;
      for (int unsigned c = 0; c < CH; c++) r[c*SW +: SW] = SW'(v[c]);
      return r;
   endfunction

   function automatic logic [CH*AW-1:0] pack_act(input int v [CH]);
      logic [CH*AW-1:0] r;
      for (int unsigned c = 0; c < CH; c++) r[c*AW +: AW] = AW'(v[c]);
      return r;
   endfunction

   // Stream beats run at shift 0 / signed mode, so every value passes through unchanged.
   function automatic logic [CH*SW-1:0] stream_sums(input int unsigned i);
      int v [CH];
      for (int unsigned c = 0; c < CH; c++) v[c] = int'(i) * 20 + int'(c) - 100;
      return pack_sums(v);
   endfunction

   function automatic logic [CH*AW-1:0] stream_act(input int unsigned i);
      int v [CH];
      for (int unsigned c = 0; c < CH; c++) v[c] = int'(i) * 20 + int'(c) - 100;
      return pack_act(v);
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_beat(input string tag);
      int unsigned n;
      @(negedge clk);
      m_if.ready = 1'b1;
      #1 chk({tag, "_sready"}, s_if.ready, 1);
      s_if.valid = 1'b1;
      s_if.data  = pack_sums(sv);
      @(negedge clk);
      s_if.valid = 1'b0;
      s_if.data  = '0;
      n = 1;
      while (m_if.valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, ST);
      chk({tag, "_data"}, m_if.data, pack_act(av));
      @(negedge clk);
      chk({tag, "_onecycle"}, m_if.valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned in_idx, out_idx, cyc, occ, stale;
      logic              held;
      logic [CH*AW-1:0]  held_data;
      logic [3:0]        pat;

      rst_n      = 1'b0;
      s_if.valid = 1'b0;
      s_if.data  = '0;
      m_if.ready = 1'b1;
      cfg_write  = 1'b0;
      cfg_shift  = '0;
      cfg_relu   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mvalid", m_if.valid, 0);
      chk("rst_mdata", m_if.data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sready", s_if.ready, 1);
      chk("rst_satcnt", sat_count, 0);
      rst_n = 1'b1;

      // Defaults: (1000 + 128) >>> 8 = 4.
      sv = '{default: 1000};
      av = '{default: 4};
      run_beat("default");

      // (300000+128)>>>8 = 1172 -> 1023; (-5000+128)>>>8 = -20 -> 0.
      sv = '{300000, -5000, 300000, -5000, 300000, -5000, 300000, -5000};
      av = '{1023, 0, 1023, 0, 1023, 0, 1023, 0};
      run_beat("relu_sat");
`ifdef STREAM_REQUANTIZE_STATS_EN
      chk("satcnt_after_clamp", sat_count, 1);
`else
      chk("satcnt_tied", sat_count, 0);
`endif

      @(negedge clk);
      cfg_write = 1'b1;
      cfg_shift = 6'd0;
      cfg_relu  = 1'b0;
      @(negedge clk);
      cfg_write = 1'b0;
      sv = '{600, -600, 7, 511, -512, 512, -513, 0};
      av = '{511, -512, 7, 511, -512, 511, -512, 0};
      run_beat("signed");
`ifdef STREAM_REQUANTIZE_STATS_EN
      chk("satcnt_signed", sat_count, 2);
`endif

      // Writes coinciding with an accept, or while busy, must be dropped.
      sv = '{100, -5, 0, 1, -1, 511, -512, 3};
      av = '{100, -5, 0, 1, -1, 511, -512, 3};
      @(negedge clk);
      m_if.ready = 1'b1;
      s_if.valid = 1'b1;
      s_if.data  = pack_sums(sv);
      cfg_write  = 1'b1;
      cfg_shift  = 6'd4;
      cfg_relu   = 1'b1;
      @(negedge clk);
      s_if.valid = 1'b0;
      chk("inflight_busy", busy, 1);
      @(negedge clk);
      cfg_write = 1'b0;
      chk("inflight_valid", m_if.valid, 1);
      chk("inflight_data", m_if.data, pack_act(av));
      @(negedge clk);
      chk("inflight_idle", busy, 0);
      run_beat("old_cfg");

      pat       = 4'b1001;
      in_idx    = 0;
      out_idx   = 0;
      cyc       = 0;
      occ       = 0;
      held      = 1'b0;
      held_data = '0;
      while (out_idx < 20 && cyc < 300) begin
         @(negedge clk);
         if (held) begin
            chk("stall_valid", m_if.valid, 1);
            chk("stall_data", m_if.data, held_data);
         end
         m_if.ready = pat[cyc % 4];
         s_if.valid = (in_idx < 20);
         s_if.data  = (in_idx < 20) ? stream_sums(in_idx) : '0;
         #1;
         chk("stream_sready", s_if.ready, !(occ == ST && !m_if.ready));
         if (m_if.valid && m_if.ready) begin
            chk("stream_data", m_if.data, stream_act(out_idx));
            out_idx++;
         end
         if (s_if.valid && s_if.ready) in_idx++;
         occ       = in_idx - out_idx;
         held      = m_if.valid && !m_if.ready;
         held_data = m_if.data;
         cyc++;
      end
      chk("stream_out_count", out_idx, 20);
      chk("stream_in_count", in_idx, 20);
      @(negedge clk);
      s_if.valid = 1'b0;
      m_if.ready = 1'b1;
      stale = 0;
      repeat (4) begin
         @(negedge clk);
         if (m_if.valid) stale++;
      end
      chk("stream_no_extra", stale, 0);

      // Fill both stages with the output stalled, then reset mid-stream.
      sv = '{default: 50};
      @(negedge clk);
      m_if.ready = 1'b0;
      s_if.valid = 1'b1;
      s_if.data  = pack_sums(sv);
      @(negedge clk);
      @(negedge clk);
      s_if.valid = 1'b0;
      chk("prerst_valid", m_if.valid, 1);
      chk("prerst_full", s_if.ready, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_valid", m_if.valid, 0);
      chk("midrst_data", m_if.data, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_satcnt", sat_count, 0);
      @(negedge clk);
      rst_n      = 1'b1;
      m_if.ready = 1'b1;
      stale = 0;
      repeat (5) begin
         @(negedge clk);
         if (m_if.valid) stale++;
      end
      chk("postrst_no_stale", stale, 0);

      // Defaults restored: 1000 -> 4, -1000 -> -4 clamped to 0 by ReLU.
      sv = '{1000, 1000, 1000, 1000, -1000, -1000, -1000, -1000};
      av = '{4, 4, 4, 4, 0, 0, 0, 0};
      run_beat("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
